cdc_2_phase_tx_feeder: RTL and testbench

Source-side feeder for the two-phase handshake CDC, in the sending (A) clock domain. It buffers a valid/ready word stream in a small FIFO and issues one word at a time to the CDC's `i_valid_A`/`i_data_A`, pacing issues on the CDC's `o_ready_A`. Each issued word is held stable on `o_data` until the next issue, so the receiving domain always samples settled data.

---
 rtl/cdc_2_phase_tx_feeder.sv | 114 +++++++++++
 tb/tb_cdc_2_phase_tx_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cdc_2_phase_tx_feeder.sv
// cdc_2_phase_tx_feeder
//   Source-side feeder for a two-phase handshake CDC. Words arriving on a
//   valid/ready stream are buffered in a small circular FIFO and issued one
//   at a time to the CDC as a single-cycle o_valid pulse. o_data is loaded
//   only at issue time and held until the next issue, so the far domain
//   always samples settled data. After each issue the CDC's ready is
//   ignored for G_BLANK cycles to cover its registered ready lag.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous reset, active low
//   i_valid  upstream word valid
//   i_data   upstream word
//   o_ready  FIFO not full (combinational from level)
//   o_valid  one-cycle issue pulse to CDC i_valid_A (registered)
//   o_data   issued word to CDC i_data_A (registered, held between issues)
//   i_ready  CDC o_ready_A
//   o_level  FIFO occupancy, 0..depth
//   o_busy   FSM not idle
module cdc_2_phase_tx_feeder #(
  parameter int G_WIDTH      = 4,
  parameter int G_DEPTH_LOG2 = 2,
  parameter int G_BLANK      = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [G_WIDTH-1:0]      i_data,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [G_WIDTH-1:0]      o_data,
  input  logic                    i_ready,
  output logic [G_DEPTH_LOG2:0]   o_level,
  output logic                    o_busy
);

  localparam int DEPTH = 1 << G_DEPTH_LOG2;
  localparam logic [G_DEPTH_LOG2:0] FULL_LVL   = (G_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [3:0]            BLANK_INIT = 4'(G_BLANK);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_BLANK} state_t;

  state_t                state, state_nxt;
  logic [G_WIDTH-1:0]    mem [DEPTH];
  // One extra MSB on each pointer separates full from empty.
  logic [G_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [3:0]            blank_cnt, blank_cnt_nxt;
  logic                  push, issue;

  assign o_level = wr_ptr - rd_ptr;
  assign o_ready = (o_level != FULL_LVL);
  // o_ready is from the pre-edge level, so a full FIFO refuses a push even
  // on the edge that pops.
  assign push    = i_valid && o_ready;
  assign o_busy  = (state != S_IDLE);

  always_comb begin
    state_nxt     = state;
    blank_cnt_nxt = blank_cnt;
    issue         = 1'b0;
    case (state)
      S_IDLE: begin
        if ((o_level != '0) && i_ready) begin
          issue     = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (G_BLANK == 0) begin
          state_nxt = S_IDLE;
        end else begin
          blank_cnt_nxt = BLANK_INIT;
          state_nxt     = S_BLANK;
        end
      end
      S_BLANK: begin
        // Leaving on count==1 makes BLANK last exactly G_BLANK cycles.
        if (blank_cnt <= 4'd1) begin
          blank_cnt_nxt = '0;
          state_nxt     = S_IDLE;
        end else begin
          blank_cnt_nxt = blank_cnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= S_IDLE;
      blank_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_cnt_nxt;
      o_valid   <= issue;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        o_data <= mem[rd_ptr[G_DEPTH_LOG2-1:0]];
      end
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[G_DEPTH_LOG2-1:0]] <= i_data;
  end

endmodule

// File: tb/tb_cdc_2_phase_tx_feeder.sv
module tb_cdc_2_phase_tx_feeder;

  localparam int W     = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int BLANK = 2;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b0;
  logic           i_valid = 1'b0;
  logic [W-1:0]   i_data = '0;
  logic           i_ready = 1'b0;
  logic           o_ready, o_valid, o_busy;
  logic [W-1:0]   o_data;
  logic [DL2:0]   o_level;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of words plus a count of cycles the feeder
  // still needs before it may issue again.
  int         mq[$];
  int         busy_left = 0;
  logic       m_valid = 1'b0;
  logic [3:0] m_data = '0;

  cdc_2_phase_tx_feeder #(.G_WIDTH(W), .G_DEPTH_LOG2(DL2), .G_BLANK(BLANK)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_level(o_level), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    busy_left = 0;
    m_valid = 1'b0;
    m_data = '0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] d, input logic r);
    bit can_push;
    bit issued;
    can_push = (mq.size() < DEPTH);
    issued = 0;
    if (busy_left > 0) busy_left--;
    else if (mq.size() > 0 && r) begin
      m_data = 4'(mq.pop_front());
      issued = 1;
      busy_left = BLANK + 1;
    end
    m_valid = issued;
    if (v && can_push) mq.push_back(int'(d));
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'(m_valid));
    chk({tag, "_data"},  32'(o_data),  32'(m_data));
    chk({tag, "_level"}, 32'(o_level), 32'(mq.size()));
    chk({tag, "_ready"}, 32'(o_ready), 32'(mq.size() < DEPTH));
    chk({tag, "_busy"},  32'(o_busy),  32'(busy_left > 0));
  endtask

  // Apply inputs, clock once, advance the model, compare 1 ns after the edge.
  task automatic cyc(input logic v, input logic [3:0] d, input logic r);
    i_valid = v; i_data = d; i_ready = r;
    @(posedge i_clk);
    model_edge(v, d, r);
    #1;
    chk_model("cyc");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_data"},  32'(o_data),  0);
    chk({tag, "_level"}, 32'(o_level), 0);
    chk({tag, "_ready"}, 32'(o_ready), 1);
    chk({tag, "_busy"},  32'(o_busy),  0);
  endtask

  // Assert reset right now (asynchronously), hold over one edge, release.
  task automatic do_reset(input string tag);
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    #1;
    chk_reset_vals(tag);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
  endtask

  typedef struct {
    logic v; logic [3:0] d; logic r;
    logic ev; logic [3:0] ed; int el; logic eb;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int t_iss[$];
    logic [3:0] d_iss[$];
    logic [3:0] held;
    bit seen;
    int w, t;

    // Single word 0xA then 0x3 across a blank window (G_BLANK=2).
    tbl[0] = '{1'b1, 4'hA, 1'b1, 1'b0, 4'h0, 1, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'hA, 0, 1'b1};
    tbl[2] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hA, 0, 1'b1};
    tbl[3] = '{1'b1, 4'h3, 1'b1, 1'b0, 4'hA, 1, 1'b1};
    tbl[4] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hA, 1, 1'b0};
    tbl[5] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 0, 1'b1};
    tbl[6] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 0, 1'b1};

    // Reset then idle for 20 cycles.
    do_reset("rst0");
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'h0, 1'b1);

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("tbl_valid", 32'(o_valid), 32'(tbl[i].ev));
      chk("tbl_data",  32'(o_data),  32'(tbl[i].ed));
      chk("tbl_level", 32'(o_level), 32'(tbl[i].el));
      chk("tbl_busy",  32'(o_busy),  32'(tbl[i].eb));
    end

    // Fill and overflow: 0x5 is dropped, then drained in order 4 cycles apart.
    do_reset("rst1");
    for (int k = 1; k <= 5; k++) cyc(1'b1, 4'(k), 1'b0);
    chk("fill_level", 32'(o_level), 4);
    chk("fill_ready", 32'(o_ready), 0);
    for (int c = 0; c < 40; c++) begin
      cyc(1'b0, 4'h0, 1'b1);
      if (o_valid) begin t_iss.push_back(c); d_iss.push_back(o_data); end
    end
    chk("fill_count", 32'(t_iss.size()), 4);
    for (int k = 0; k < t_iss.size() && k < 4; k++) begin
      chk("fill_order", 32'(d_iss[k]), 32'(k + 1));
      if (k > 0) chk("fill_spacing", 32'(t_iss[k] - t_iss[k-1]), BLANK + 2);
    end

    // Back-pressure: i_ready low for 30 cycles after the first issue.
    do_reset("rst2");
    cyc(1'b1, 4'h6, 1'b0);
    cyc(1'b1, 4'h9, 1'b0);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cyc(1'b0, 4'h0, 1'b1);
      seen = o_valid;
    end
    chk("bp_first_issue", 32'(seen), 1);
    held = o_data;
    chk("bp_first_data", 32'(held), 32'h6);
    for (int c = 0; c < 30; c++) begin
      cyc(1'b0, 4'h0, 1'b0);
      if (o_valid || o_data !== held) chk("bp_hold", {o_valid, 27'd0, o_data}, {1'b0, 27'd0, held});
    end
    chk("bp_stable", 32'(o_data), 32'(held));
    cyc(1'b0, 4'h0, 1'b1);
    chk("bp_resume_valid", 32'(o_valid), 1);
    chk("bp_resume_data", 32'(o_data), 32'h9);

    // Simultaneous push/pop at level 2, then 3*depth words through the FIFO.
    do_reset("rst3");
    cyc(1'b1, 4'h0, 1'b0);
    cyc(1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h2, 1'b1);
    chk("pp_valid", 32'(o_valid), 1);
    chk("pp_level", 32'(o_level), 2);
    d_iss.delete();
    d_iss.push_back(o_data);
    w = 3;
    t = 0;
    while (d_iss.size() < 3*DEPTH && t < 200) begin
      logic acc;
      acc = o_ready && (w < 3*DEPTH);
      cyc(w < 3*DEPTH, 4'(w), 1'b1);
      if (acc) w++;
      if (o_valid) d_iss.push_back(o_data);
      t++;
    end
    chk("pp_words", 32'(d_iss.size()), 3*DEPTH);
    for (int k = 0; k < d_iss.size(); k++) chk("pp_order", 32'(d_iss[k]), 32'(k % 16));

    // Mid-operation reset during BLANK with 3 words queued.
    do_reset("rst4");
    for (int k = 0; k < 4; k++) cyc(1'b1, 4'(8 + k), 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    chk("mid_busy", 32'(o_busy), 1);
    chk("mid_level", 32'(o_level), 3);
    do_reset("mid_rst");
    for (int c = 0; c < 20; c++) begin
      cyc(1'b0, 4'h0, 1'b1);
      if (o_valid) chk("mid_stale", 32'(o_valid), 0);
    end

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else cyc(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
